// File: rtl/fnd_pkg.sv
// rtl/fnd_pkg.sv - shared glyph table, segment bit map and scan states
package fnd_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Active-high encoding; polarity is applied at the pins.
  localparam logic [7:0] SEG_OFF = 8'h00;

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} scan_state_e;

  function automatic logic [6:0] glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      4'hF: g = 7'h71;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/fnd_hex_glyph.sv
// rtl/fnd_hex_glyph.sv - nibble, decimal point and blank to one segment word
module fnd_hex_glyph
  import fnd_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] nibble,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] seg
);

  logic [7:0] seg_hi;

  always_comb begin
    seg_hi = SEG_OFF;
    if (!blank) begin
      seg_hi[SEG_G:SEG_A] = glyph(nibble);
      seg_hi[SEG_DP]      = dp;
    end
    seg = ACTIVE_LOW ? ~seg_hi : seg_hi;
  end

endmodule

// File: rtl/wm_fnd_scan.sv
// rtl/wm_fnd_scan.sv - multi-digit time-multiplexed 7-segment scan controller
module wm_fnd_scan
  import fnd_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_HZ         = 48000000,
  parameter int SCAN_HZ        = 1000,
  parameter int BLANK_CYCLES   = 48,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digit_data,
  input  logic [NUM_DIGITS-1:0]   digit_off,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    lz_blank,
  output logic [7:0]              seg_data,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_done
);

  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [TW-1:0] T_LAST  = TW'(DIV - 1);
  localparam logic [TW-1:0] T_BLANK = TW'(BLANK_CYCLES);
  localparam logic [IW-1:0] I_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [7:0] SEG_IDLE = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
  localparam logic [NUM_DIGITS-1:0] DIG_IDLE = DIG_ACTIVE_LOW ? '1 : '0;

  if (DIV < BLANK_CYCLES + 1) begin : g_bad_div
    $error("wm_fnd_scan: slot shorter than dead time");
  end

  scan_state_e           state, state_nx;
  logic [TW-1:0]         timer, timer_nx;
  logic [IW-1:0]         idx, idx_nx;
  logic [4*NUM_DIGITS-1:0] sh_data, act_data;
  logic [NUM_DIGITS-1:0] sh_off, act_off, sh_dp, act_dp, dig_hot;
  logic                  sh_lz, act_lz, pending, boundary;
  logic [3:0]            cur_nib;
  logic                  cur_dp, cur_off, lz_hit;
  logic [7:0]            seg_word;

  always_comb begin
    state_nx = state;
    timer_nx = timer;
    idx_nx   = idx;
    if (!en) begin
      state_nx = IDLE;
      timer_nx = '0;
      idx_nx   = '0;
    end else if (state == IDLE) begin
      state_nx = BLANK;
      timer_nx = '0;
      idx_nx   = '0;
    end else begin
      if (timer == T_LAST) begin
        timer_nx = '0;
        idx_nx   = (idx == I_LAST) ? '0 : idx + IW'(1);
      end else begin
        timer_nx = timer + TW'(1);
      end
      state_nx = (timer_nx < T_BLANK) ? BLANK : SHOW;
    end
  end

  assign boundary = (state != IDLE) && (timer == T_LAST) && (idx == I_LAST);

  // Leading-zero hit: every nibble at or above the current digit is zero.
  always_comb begin
    cur_nib = '0;
    cur_dp  = 1'b0;
    cur_off = 1'b0;
    dig_hot = '0;
    lz_hit  = act_lz && (idx != '0);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IW'(i) == idx) begin
        cur_nib    = act_data[4*i +: 4];
        cur_dp     = act_dp[i];
        cur_off    = act_off[i];
        dig_hot[i] = 1'b1;
      end
      if (IW'(i) >= idx && act_data[4*i +: 4] != 4'h0) lz_hit = 1'b0;
    end
  end

  fnd_hex_glyph #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_glyph (
    .nibble (cur_nib),
    .dp     (cur_dp),
    .blank  (cur_off | lz_hit),
    .seg    (seg_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      timer      <= '0;
      idx        <= '0;
      seg_data   <= SEG_IDLE;
      dig_sel    <= DIG_IDLE;
      frame_done <= 1'b0;
      sh_data    <= '0;
      sh_off     <= '1;
      sh_dp      <= '0;
      sh_lz      <= 1'b0;
      act_data   <= '0;
      act_off    <= '1;
      act_dp     <= '0;
      act_lz     <= 1'b0;
      pending    <= 1'b0;
    end else begin
      state <= state_nx;
      timer <= timer_nx;
      idx   <= idx_nx;
      if (en && state == SHOW) begin
        seg_data <= seg_word;
        dig_sel  <= DIG_ACTIVE_LOW ? ~dig_hot : dig_hot;
      end else begin
        seg_data <= SEG_IDLE;
        dig_sel  <= DIG_IDLE;
      end
      frame_done <= boundary && (pending || load);
      if (load) begin
        sh_data <= digit_data;
        sh_off  <= digit_off;
        sh_dp   <= dp;
        sh_lz   <= lz_blank;
      end
      // Idle or frame-boundary loads bypass the shadow so nothing waits a frame.
      if (load && (state == IDLE || boundary)) begin
        act_data <= digit_data;
        act_off  <= digit_off;
        act_dp   <= dp;
        act_lz   <= lz_blank;
        pending  <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end else if (boundary && pending) begin
        act_data <= sh_data;
        act_off  <= sh_off;
        act_dp   <= sh_dp;
        act_lz   <= sh_lz;
        pending  <= 1'b0;
      end
    end
  end

endmodule
